mul_result_buffer: RTL and testbench
====================================

// Module: mul_result_buffer
// PURPOSE
//  Egress stage for the N.Q AXI4-S multiplier wrapper. That wrapper emits one product beat
//  (tdata, tid, tuser = overflow) with no tready, so this block absorbs it into a small
//  first-word-fall-through FIFO and re-presents it as a back-pressurable AXI4-S stream.
//  Counts overflowed results and results dropped on full; almost_full throttles the operand source.
// PARAMETERS
//  AXI_DATA_WIDTH_P  32  product/data width
//  AXI_ID_WIDTH_P    4   tid width
//  FIFO_DEPTH_P      4   entries; power of two, >= 2
//  CNT_WIDTH_P       16  width of ovf_count / drop_count
// PORTS
//  clk           in   1                      clock
//  rst_n         in   1                      asynchronous reset, active-low
//  ing_tvalid    in   1                      result beat from multiplier (no tready)
//  ing_tdata     in   AXI_DATA_WIDTH_P       product
//  ing_tid       in   AXI_ID_WIDTH_P         transaction id
//  ing_tuser     in   1                      overflow flag of product
//  egr_tvalid    out  1                      buffered result available
//  egr_tready    in   1                      downstream accept
//  egr_tdata     out  AXI_DATA_WIDTH_P       head-of-FIFO product
//  egr_tlast     out  1                      constant 1 (single-beat packets)
//  egr_tid       out  AXI_ID_WIDTH_P         head-of-FIFO id
//  egr_tuser     out  1                      head-of-FIFO overflow flag
//  fill_level    out  $clog2(FIFO_DEPTH_P)+1 occupied entries
//  almost_full   out  1                      fill_level >= FIFO_DEPTH_P-1
//  clr_counters  in   1                      synchronous clear of both counters
//  ovf_count     out  CNT_WIDTH_P            accepted beats with tuser=1, saturating
//  drop_count    out  CNT_WIDTH_P            beats lost on full, saturating
// BEHAVIOUR
//  - Reset: clk is clk; rst_n is asynchronous, active-low. FIFO flushed (pointers 0), egr_tvalid=0,
//    egr_tdata/tid/tuser=0, egr_tlast=1, fill_level=0, almost_full=0, counters=0. Reset mid-stream
//    discards all stored entries; no partial beat survives.
//  - Pointers: $clog2(FIFO_DEPTH_P)+1 bits, MSB wrap bit; full = MSBs differ & rest equal; empty = equal.
//  - Write: ing_tvalid & (!full | pop) -> store {tdata,tid,tuser} at wr_ptr, wr_ptr++.
//  - Read/pop: egr_tvalid & egr_tready -> rd_ptr++. egr_tvalid = !empty; egr_* driven from
//    entry at rd_ptr (FWFT), stable while egr_tvalid & !egr_tready.
//  - Latency: beat written in cycle N is on egr_* in cycle N+1. No same-cycle bypass when empty.
//  - Full + push + pop same cycle: push accepted, fill_level unchanged, no drop.
//  - Full + push, no pop: beat dropped, FIFO untouched, drop_count++ (saturate at all-ones).
//  - ovf_count++ only for accepted beats with ing_tuser=1; saturates at all-ones.
//  - clr_counters: counter <= 0, then any same-cycle event is added (result 1, not 0).
//  - fill_level/almost_full registered from pointers; update cycle after push/pop.
//  - No state machine beyond FIFO pointers; all outputs registered or decoded from registers.
// TESTING
//  1. Reset, single beat tdata=0x0001_8000,tid=3,tuser=0 -> egr_tvalid next cycle, same data, tlast=1.
//  2. egr_tready=0, push 4 beats (DEPTH=4) -> fill 4, almost_full at 3; 5th push -> drop_count=1, data kept.
//  3. Full, push+pop same cycle -> fill stays 4, drop_count unchanged, order preserved.
//  4. 3 beats tuser=1, 1 tuser=0 -> ovf_count=3; clr_counters with tuser=1 push same cycle -> ovf_count=1.
//  5. CNT_WIDTH_P=2, 5 drops -> drop_count holds 3.
//  6. rst_n low with 2 stored entries -> egr_tvalid=0 immediately, fill 0; next push appears alone.

Source files
------------

// File: rtl/mul_result_buffer.sv
// Egress buffer for the multiplier wrapper: a first-word-fall-through FIFO that turns the
// tready-less product beat into a back-pressurable stream, with overflow and drop counters.
module mul_result_buffer #(
    parameter int AXI_DATA_WIDTH_P = 32,
    parameter int AXI_ID_WIDTH_P   = 4,
    parameter int FIFO_DEPTH_P     = 4,
    parameter int CNT_WIDTH_P      = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              ing_tvalid,
    input  logic [AXI_DATA_WIDTH_P-1:0]       ing_tdata,
    input  logic [AXI_ID_WIDTH_P-1:0]         ing_tid,
    input  logic                              ing_tuser,
    output logic                              egr_tvalid,
    input  logic                              egr_tready,
    output logic [AXI_DATA_WIDTH_P-1:0]       egr_tdata,
    output logic                              egr_tlast,
    output logic [AXI_ID_WIDTH_P-1:0]         egr_tid,
    output logic                              egr_tuser,
    output logic [$clog2(FIFO_DEPTH_P):0]     fill_level,
    output logic                              almost_full,
    input  logic                              clr_counters,
    output logic [CNT_WIDTH_P-1:0]            ovf_count,
    output logic [CNT_WIDTH_P-1:0]            drop_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH_P) + 1;
    localparam int IDX_W = PTR_W - 1;
    localparam int ENT_W = AXI_DATA_WIDTH_P + AXI_ID_WIDTH_P + 1;

    // Counters stick at all-ones rather than wrapping back to a misleadingly small value.
    function automatic logic [CNT_WIDTH_P-1:0] sat_inc(
        input logic [CNT_WIDTH_P-1:0] cnt,
        input logic                   inc
    );
        if (inc && (cnt != {CNT_WIDTH_P{1'b1}})) begin
            return cnt + {{(CNT_WIDTH_P-1){1'b0}}, 1'b1};
        end else begin
            return cnt;
        end
    endfunction

    logic [ENT_W-1:0] mem_q [FIFO_DEPTH_P];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] fill_q, fill_d;
    logic             almost_full_q, almost_full_d;
    logic [CNT_WIDTH_P-1:0] ovf_q, ovf_d;
    logic [CNT_WIDTH_P-1:0] drop_q, drop_d;

    logic             full_s;
    logic             empty_s;
    logic             pop_s;
    logic             push_s;
    logic             drop_s;
    logic [ENT_W-1:0] head_s;

    assign empty_s = (wr_ptr_q == rd_ptr_q);
    assign full_s  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                     (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign pop_s   = !empty_s && egr_tready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push_s  = ing_tvalid && (!full_s || pop_s);
    assign drop_s  = ing_tvalid && full_s && !pop_s;
    assign head_s  = mem_q[rd_ptr_q[IDX_W-1:0]];

    // Next-state for pointers, occupancy and counters.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        fill_d        = fill_q;
        almost_full_d = almost_full_q;
        ovf_d         = ovf_q;
        drop_d        = drop_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        fill_d        = wr_ptr_d - rd_ptr_d;
        almost_full_d = (fill_d >= PTR_W'(FIFO_DEPTH_P - 1));

        // Clear first, then fold in this cycle's event so nothing is lost.
        if (clr_counters) begin
            ovf_d  = sat_inc({CNT_WIDTH_P{1'b0}}, push_s && ing_tuser);
            drop_d = sat_inc({CNT_WIDTH_P{1'b0}}, drop_s);
        end else begin
            ovf_d  = sat_inc(ovf_q, push_s && ing_tuser);
            drop_d = sat_inc(drop_q, drop_s);
        end
    end

    // Pointer, occupancy and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= {PTR_W{1'b0}};
            rd_ptr_q      <= {PTR_W{1'b0}};
            fill_q        <= {PTR_W{1'b0}};
            almost_full_q <= 1'b0;
            ovf_q         <= {CNT_WIDTH_P{1'b0}};
            drop_q        <= {CNT_WIDTH_P{1'b0}};
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fill_q        <= fill_d;
            almost_full_q <= almost_full_d;
            ovf_q         <= ovf_d;
            drop_q        <= drop_d;
        end
    end

    // Storage is cleared on reset so the head fields read zero until the first beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH_P; i++) begin
                mem_q[i] <= {ENT_W{1'b0}};
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q[IDX_W-1:0]] <= {ing_tdata, ing_tid, ing_tuser};
        end else begin
            mem_q[wr_ptr_q[IDX_W-1:0]] <= mem_q[wr_ptr_q[IDX_W-1:0]];
        end
    end

    assign egr_tvalid  = !empty_s;
    assign egr_tdata   = head_s[ENT_W-1 -: AXI_DATA_WIDTH_P];
    assign egr_tid     = head_s[AXI_ID_WIDTH_P:1];
    assign egr_tuser   = head_s[0];
    assign egr_tlast   = 1'b1;
    assign fill_level  = fill_q;
    assign almost_full = almost_full_q;
    assign ovf_count   = ovf_q;
    assign drop_count  = drop_q;

endmodule

// File: tb/tb_mul_result_buffer.sv
// Directed bench for mul_result_buffer: a queue model checked every cycle, plus literal
// expectations for the reset state, throttling, drops, counter clearing and mid-stream reset.
module tb_mul_result_buffer;

    localparam int DEPTH = 4;
    localparam int MAX1  = 65535;
    localparam int MAX2  = 3;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  id;
        logic        u;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        ing_tvalid;
    logic [31:0] ing_tdata;
    logic [3:0]  ing_tid;
    logic        ing_tuser;
    logic        egr_tready;
    logic        clr_counters;

    logic        egr_tvalid, egr_tlast, egr_tuser, almost_full;
    logic [31:0] egr_tdata;
    logic [3:0]  egr_tid;
    logic [2:0]  fill_level;
    logic [15:0] ovf_count, drop_count;

    logic        egr_tvalid2, egr_tlast2, egr_tuser2, almost_full2;
    logic [31:0] egr_tdata2;
    logic [3:0]  egr_tid2;
    logic [2:0]  fill_level2;
    logic [1:0]  ovf_count2, drop_count2;

    int checks = 0;
    int errors = 0;

    beat_t mq[$];
    int    m_ovf1, m_drop1, m_ovf2, m_drop2;
    bit    m_pop, m_push, m_drop;

    mul_result_buffer dut (
        .clk(clk), .rst_n(rst_n),
        .ing_tvalid(ing_tvalid), .ing_tdata(ing_tdata), .ing_tid(ing_tid), .ing_tuser(ing_tuser),
        .egr_tvalid(egr_tvalid), .egr_tready(egr_tready), .egr_tdata(egr_tdata),
        .egr_tlast(egr_tlast), .egr_tid(egr_tid), .egr_tuser(egr_tuser),
        .fill_level(fill_level), .almost_full(almost_full), .clr_counters(clr_counters),
        .ovf_count(ovf_count), .drop_count(drop_count)
    );

    mul_result_buffer #(.CNT_WIDTH_P(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .ing_tvalid(ing_tvalid), .ing_tdata(ing_tdata), .ing_tid(ing_tid), .ing_tuser(ing_tuser),
        .egr_tvalid(egr_tvalid2), .egr_tready(egr_tready), .egr_tdata(egr_tdata2),
        .egr_tlast(egr_tlast2), .egr_tid(egr_tid2), .egr_tuser(egr_tuser2),
        .fill_level(fill_level2), .almost_full(almost_full2), .clr_counters(clr_counters),
        .ovf_count(ovf_count2), .drop_count(drop_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int base, input bit inc, input int max);
        return (inc && base < max) ? base + 1 : base;
    endfunction

    // Reference model: a bounded queue with saturating counters.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_ovf1  <= 0;
            m_drop1 <= 0;
            m_ovf2  <= 0;
            m_drop2 <= 0;
        end else begin
            m_pop  = (mq.size() > 0) && egr_tready;
            m_push = ing_tvalid && ((mq.size() < DEPTH) || m_pop);
            m_drop = ing_tvalid && !m_push;
            m_ovf1  <= sat(clr_counters ? 0 : m_ovf1,  m_push && ing_tuser, MAX1);
            m_ovf2  <= sat(clr_counters ? 0 : m_ovf2,  m_push && ing_tuser, MAX2);
            m_drop1 <= sat(clr_counters ? 0 : m_drop1, m_drop, MAX1);
            m_drop2 <= sat(clr_counters ? 0 : m_drop2, m_drop, MAX2);
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back('{d: ing_tdata, id: ing_tid, u: ing_tuser});
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("tvalid", egr_tvalid, mq.size() > 0);
        chk("tlast", egr_tlast, 1'b1);
        chk("fill", fill_level, mq.size());
        chk("almost_full", almost_full, mq.size() >= DEPTH - 1);
        chk("ovf", ovf_count, m_ovf1);
        chk("drop", drop_count, m_drop1);
        chk("ovf_w2", ovf_count2, m_ovf2);
        chk("drop_w2", drop_count2, m_drop2);
        if (mq.size() > 0) begin
            chk("tdata", egr_tdata, mq[0].d);
            chk("tid", egr_tid, mq[0].id);
            chk("tuser", egr_tuser, mq[0].u);
        end
    end

    task automatic cyc(input logic v, input logic [31:0] d, input logic [3:0] id,
                       input logic u, input logic rdy, input logic clr);
        @(negedge clk);
        #1;
        ing_tvalid   = v;
        ing_tdata    = d;
        ing_tid      = id;
        ing_tuser    = u;
        egr_tready   = rdy;
        clr_counters = clr;
        @(posedge clk);
        #1;
        ing_tvalid   = 1'b0;
        egr_tready   = 1'b0;
        clr_counters = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ing_tvalid = 1'b0; ing_tdata = 32'h0; ing_tid = 4'h0;
        ing_tuser = 1'b0; egr_tready = 1'b0; clr_counters = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_tvalid", egr_tvalid, 1'b0);
        chk("rst_tdata", egr_tdata, 32'h0);
        chk("rst_tlast", egr_tlast, 1'b1);
        chk("rst_fill", fill_level, 3'd0);
        chk("rst_drop", drop_count, 16'd0);

        // Single beat, one-cycle latency, no bypass
        @(negedge clk);
        #1;
        ing_tvalid = 1'b1; ing_tdata = 32'h0001_8000; ing_tid = 4'd3; ing_tuser = 1'b0;
        #1 chk("no_bypass", egr_tvalid, 1'b0);
        @(posedge clk);
        #1 ing_tvalid = 1'b0;
        @(negedge clk);
        chk("t1_tvalid", egr_tvalid, 1'b1);
        chk("t1_tdata", egr_tdata, 32'h0001_8000);
        chk("t1_tid", egr_tid, 4'd3);
        cyc(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("t1_drained", egr_tvalid, 1'b0);

        // Fill to full, throttle at 3, drop the 5th
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 32'hA000_0000 + i, 4'(i), 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            if (i == 2) begin
                chk("t2_af3", almost_full, 1'b1);
                chk("t2_fill3", fill_level, 3'd3);
            end
            if (i == 1) chk("t2_af2", almost_full, 1'b0);
        end
        chk("t2_fill4", fill_level, 3'd4);
        cyc(1'b1, 32'hA000_0004, 4'd4, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t2_drop1", drop_count, 16'd1);
        chk("t2_head", egr_tdata, 32'hA000_0000);
        chk("t2_fill", fill_level, 3'd4);

        // Full with push and pop together
        cyc(1'b1, 32'hB000_0000, 4'd5, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("t3_fill", fill_level, 3'd4);
        chk("t3_drop", drop_count, 16'd1);
        chk("t3_head", egr_tdata, 32'hA000_0001);

        // Drop saturation on the 2-bit instance
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'hE000_0000 + i, 4'd6, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("t5_drop16", drop_count, 16'd5);
        chk("t5_drop2", drop_count2, 2'd3);
        chk("t5_ovf_dropped", ovf_count, 16'd0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("t5_empty", egr_tvalid, 1'b0);

        // Overflow counting and clear-with-event
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'hC000_0000 + i, 4'(i + 8), i < 3, 1'b0, 1'b0);
        @(negedge clk);
        chk("t4_ovf3", ovf_count, 16'd3);
        chk("t4_ovf3_w2", ovf_count2, 2'd3);
        cyc(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 32'hC000_0010, 4'd7, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("t4_clr_ovf", ovf_count, 16'd1);
        chk("t4_clr_drop", drop_count, 16'd0);
        chk("t4_fill", fill_level, 3'd4);

        // Mid-stream reset
        for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 32'hF000_0001, 4'd1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hF000_0002, 4'd2, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("t6_fill2", fill_level, 3'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_tvalid", egr_tvalid, 1'b0);
        chk("t6_rst_fill", fill_level, 3'd0);
        chk("t6_rst_ovf", ovf_count, 16'd0);
        #1 rst_n = 1'b1;
        cyc(1'b1, 32'hD000_0000, 4'd9, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t6_tvalid", egr_tvalid, 1'b1);
        chk("t6_tdata", egr_tdata, 32'hD000_0000);
        chk("t6_fill1", fill_level, 3'd1);
        cyc(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("t6_alone", egr_tvalid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
